sdp_mrdma_rd_credit_sched: RTL and testbench
============================================

// Module: sdp_mrdma_rd_credit_sched
// PURPOSE
//  Layer-level read scheduler for SDP MRDMA. Gates read requests from the ingress request generator to the DMA
//  read port against free latency-FIFO credits, so read responses never overflow the egress latency FIFO.
//  Credits return on each egress dma_rd_cdt_lat_fifo_pop. Sequences a layer: op_load -> issue -> drain -> layer_done.
// PARAMETERS
//  LAT_DEPTH   256  latency-FIFO entries (credits) owned by MRDMA egress
//  CNT_W       9    credit counter width, $clog2(LAT_DEPTH+1)
//  REQ_W       22   width of per-layer request count
// PORTS
//  nvdla_core_clk           in   1      core clock
//  nvdla_core_rst           in   1      asynchronous, active-high reset
//  op_load                  in   1      layer start pulse
//  reg2dp_req_num           in   REQ_W  DMA read requests in this layer, sampled on op_load
//  ig_req_vld               in   1      ingress has a read request
//  ig_req_size              in   2      request size in atoms minus 1 (1..4 atoms)
//  ig_req_rdy               out  1      request accepted
//  dma_rd_req_vld           out  1      request presented to DMA read port
//  dma_rd_req_rdy           in   1      DMA read port accepts
//  dma_rd_cdt_lat_fifo_pop  in   1      one latency-FIFO entry freed (one credit returned)
//  eg_done                  in   1      egress finished the layer (pulse)
//  layer_done               out  1      one-cycle pulse: layer fully issued, drained, egress done
//  sched_busy               out  1      state != IDLE
//  credit_avail             out  CNT_W  current free credits
//  credit_err               out  1      sticky: credit return while already at LAT_DEPTH
//  dp2reg_credit_stall_num  out  32     stall cycles (optional feature)
// BEHAVIOUR
//  Reset: state=IDLE, credit=LAT_DEPTH, remaining=0, eg_seen=0; all outputs 0 except credit_avail=LAT_DEPTH.
//  need = ig_req_size+1. ok = (state==RUN) && (remaining!=0) && (credit>=need).
//  dma_rd_req_vld = ig_req_vld && ok; ig_req_rdy = dma_rd_req_rdy && ok  (combinational, zero latency).
//  accept = ig_req_vld && ig_req_rdy. Never depends on dma_rd_req_rdy in vld (no vld/rdy loop).
//  Credit next = credit - (accept ? need : 0) + pop, one register update; simultaneous accept+pop both applied.
//  Pop with credit==LAT_DEPTH and no accept: credit holds, credit_err set (cleared only by reset).
//  remaining loads reg2dp_req_num on op_load, decrements by 1 per accept.
//  FSM: IDLE --op_load--> RUN (remaining!=0) or DRAIN (req_num==0).
//       RUN  --accept with remaining==1--> DRAIN.
//       DRAIN --credit==LAT_DEPTH && eg_seen--> DONE.  DONE --1 cycle--> IDLE, layer_done=1 in DONE.
//  eg_seen set by eg_done in RUN/DRAIN (may precede last credit return), cleared entering IDLE.
//  op_load outside IDLE is ignored. Credits are not reset between layers (pops of prior layer still count).
//  layer_done registered: asserted exactly the cycle state==DONE.
// CONFIGURATION
//  NVDLA_SDP_MRDMA_CREDIT_PERF_EN defined: 32-bit counter, cleared on op_load, +1 each cycle
//   ig_req_vld && state==RUN && remaining!=0 && credit<need; saturates at 32'hFFFFFFFF.
//  Not defined: dp2reg_credit_stall_num tied to 32'h0, no counter flops.
// STRUCTURE
//  Shared package sdp_mrdma_pkg: state enum {IDLE,RUN,DRAIN,DONE}, LAT_DEPTH default, atom-size constants.
//  One sub-module: sdp_mrdma_credit_cnt (credit register, accept/pop arithmetic, overflow flag).
//  FSM, remaining counter and perf counter stay in top.
// TESTING
//  1 op_load req_num=3, size=3, rdy=1, no pops -> 3 accepts on consecutive cycles, credit 256->244, state DRAIN.
//  2 LAT_DEPTH=8, size=3 repeatedly, no pops -> 2 accepts, credit=0, vld low; one pop -> still stalled (1<4);
//    three more pops -> next accept; PERF_EN counter equals stalled cycles.
//  3 accept(size=1) and pop same cycle at credit=5 -> credit=4.
//  4 req_num=0 with eg_done 2 cycles later, credit full -> DRAIN, layer_done single pulse 1 cycle after eg_done seen.
//  5 eg_done before last 4 pops -> layer_done only after credit returns to LAT_DEPTH; pop at full -> credit_err=1.
//  6 reset asserted mid-RUN with credit=100 -> immediately IDLE, credit=256, vld/rdy low; op_load in RUN ignored.

Source files
------------

// File: rtl/sdp_mrdma_pkg.sv
// Shared types and constants for the SDP MRDMA read credit scheduler.
// Holds the layer FSM state encoding and the request-size to atom-count helper.
package sdp_mrdma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int LAT_DEPTH_DEF = 256;
  localparam int SIZE_W        = 2;
  localparam int ATOM_MAX      = 4;
  localparam int NEED_W        = 3;

  // Request size is encoded as atoms minus one.
  function automatic logic [NEED_W-1:0] atom_need(input logic [SIZE_W-1:0] size);
    return {1'b0, size} + 3'd1;
  endfunction

endpackage

// File: rtl/sdp_mrdma_credit_cnt.sv
// Latency-FIFO credit counter: subtracts atoms on accept, adds one per egress pop.
// Latency: registered, new credit visible the cycle after accept/pop.
// Backpressure: none; overflowing returns are dropped and flagged sticky in credit_err.
module sdp_mrdma_credit_cnt
  import sdp_mrdma_pkg::*;
#(
  parameter int LAT_DEPTH = LAT_DEPTH_DEF,
  parameter int CNT_W     = $clog2(LAT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [NEED_W-1:0] need,
  input  logic              pop,
  output logic [CNT_W-1:0]  credit,
  output logic              credit_err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(LAT_DEPTH);

  logic [CNT_W-1:0] need_ext;
  logic [CNT_W-1:0] pop_ext;
  logic [CNT_W-1:0] credit_nxt;
  logic             overflow;

  always_comb begin
    need_ext   = accept ? {{(CNT_W-NEED_W){1'b0}}, need} : '0;
    pop_ext    = {{(CNT_W-1){1'b0}}, pop};
    credit_nxt = credit - need_ext + pop_ext;
    // A return with nothing outstanding means egress and scheduler disagree.
    overflow   = pop && !accept && (credit == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit     <= FULL;
      credit_err <= 1'b0;
    end else if (overflow) begin
      credit_err <= 1'b1;
    end else begin
      credit     <= credit_nxt;
    end
  end

endmodule

// File: rtl/sdp_mrdma_rd_credit_sched.sv
// Layer read scheduler: gates ingress read requests onto the DMA port against latency-FIFO credits.
// Latency: zero-cycle request pass-through; layer_done registered. Optional NVDLA_SDP_MRDMA_CREDIT_PERF_EN.
// Backpressure: requests held off (vld/rdy low) while credits are short or the layer is fully issued.
module sdp_mrdma_rd_credit_sched
  import sdp_mrdma_pkg::*;
#(
  parameter int LAT_DEPTH = LAT_DEPTH_DEF,
  parameter int CNT_W     = $clog2(LAT_DEPTH + 1),
  parameter int REQ_W     = 22
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              op_load,
  input  logic [REQ_W-1:0]  reg2dp_req_num,
  input  logic              ig_req_vld,
  input  logic [SIZE_W-1:0] ig_req_size,
  output logic              ig_req_rdy,
  output logic              dma_rd_req_vld,
  input  logic              dma_rd_req_rdy,
  input  logic              dma_rd_cdt_lat_fifo_pop,
  input  logic              eg_done,
  output logic              layer_done,
  output logic              sched_busy,
  output logic [CNT_W-1:0]  credit_avail,
  output logic              credit_err,
  output logic [31:0]       dp2reg_credit_stall_num
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(LAT_DEPTH);

  sched_state_e     state;
  logic [REQ_W-1:0] remaining;
  logic             eg_seen;
  logic [NEED_W-1:0] need;
  logic [CNT_W-1:0] need_ext;
  logic             ok;
  logic             accept;

  always_comb begin
    need     = atom_need(ig_req_size);
    need_ext = {{(CNT_W-NEED_W){1'b0}}, need};
    ok       = (state == RUN) && (remaining != '0) && (credit_avail >= need_ext);
  end

  // Valid never looks at the DMA ready, so no combinational loop through the port.
  assign dma_rd_req_vld = ig_req_vld && ok;
  assign ig_req_rdy     = dma_rd_req_rdy && ok;
  assign accept         = ig_req_vld && ig_req_rdy;
  assign sched_busy     = (state != IDLE);

  sdp_mrdma_credit_cnt #(
    .LAT_DEPTH (LAT_DEPTH),
    .CNT_W     (CNT_W)
  ) u_credit_cnt (
    .clk        (nvdla_core_clk),
    .rst        (nvdla_core_rst),
    .accept     (accept),
    .need       (need),
    .pop        (dma_rd_cdt_lat_fifo_pop),
    .credit     (credit_avail),
    .credit_err (credit_err)
  );

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state      <= IDLE;
      remaining  <= '0;
      eg_seen    <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      case (state)
        IDLE: begin
          eg_seen <= 1'b0;
          if (op_load) begin
            remaining <= reg2dp_req_num;
            state     <= (reg2dp_req_num != '0) ? RUN : DRAIN;
          end
        end
        RUN: begin
          if (eg_done) eg_seen <= 1'b1;
          if (accept) begin
            remaining <= remaining - 1'b1;
            if (remaining == REQ_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (eg_done) eg_seen <= 1'b1;
          // eg_done may arrive before the last credits come home; wait for both.
          if ((credit_avail == FULL) && eg_seen) begin
            state      <= DONE;
            layer_done <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          eg_seen <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NVDLA_SDP_MRDMA_CREDIT_PERF_EN
  logic        stall;
  logic [31:0] stall_cnt;

  assign stall = ig_req_vld && (state == RUN) && (remaining != '0) && (credit_avail < need_ext);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stall_cnt <= 32'h0;
    end else if (op_load && (state == IDLE)) begin
      stall_cnt <= 32'h0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'h1;
    end
  end

  assign dp2reg_credit_stall_num = stall_cnt;
`else
  assign dp2reg_credit_stall_num = 32'h0;
`endif

endmodule

// File: tb/tb_sdp_mrdma_rd_credit_sched.sv
// Directed bench for sdp_mrdma_rd_credit_sched with hand-computed expectations.
module tb_sdp_mrdma_rd_credit_sched;

  localparam int LAT_DEPTH = 256;
  localparam int CNT_W     = 9;
  localparam int REQ_W     = 22;

  logic             clk;
  logic             rst;
  logic             op_load;
  logic [REQ_W-1:0] req_num;
  logic             ig_vld;
  logic [1:0]       ig_size;
  logic             ig_rdy;
  logic             dma_vld;
  logic             dma_rdy;
  logic             pop;
  logic             eg_done;
  logic             layer_done;
  logic             busy;
  logic [CNT_W-1:0] credit;
  logic             cerr;
  logic [31:0]      stall_num;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  sdp_mrdma_rd_credit_sched #(
    .LAT_DEPTH (LAT_DEPTH),
    .CNT_W     (CNT_W),
    .REQ_W     (REQ_W)
  ) dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rst          (rst),
    .op_load                 (op_load),
    .reg2dp_req_num          (req_num),
    .ig_req_vld              (ig_vld),
    .ig_req_size             (ig_size),
    .ig_req_rdy              (ig_rdy),
    .dma_rd_req_vld          (dma_vld),
    .dma_rd_req_rdy          (dma_rdy),
    .dma_rd_cdt_lat_fifo_pop (pop),
    .eg_done                 (eg_done),
    .layer_done              (layer_done),
    .sched_busy              (busy),
    .credit_avail            (credit),
    .credit_err              (cerr),
    .dp2reg_credit_stall_num (stall_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op_load = 1'b0; req_num = '0; ig_vld = 1'b0; ig_size = 2'd0;
    dma_rdy = 1'b0; pop = 1'b0; eg_done = 1'b0;
    step(); step();
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_credit", 32'(credit), 32'd256);
    chk("rst_vld", 32'(dma_vld), 32'd0);
    chk("rst_rdy", 32'(ig_rdy), 32'd0);
    chk("rst_done", 32'(layer_done), 32'd0);
    chk("rst_err", 32'(cerr), 32'd0);
    chk("rst_stall", stall_num, 32'd0);
    rst = 1'b0;
    step();

    // Three size-3 requests back to back: 256 -> 244, then drain.
    op_load = 1'b1; req_num = 22'd3;
    step();
    op_load = 1'b0;
    ig_vld = 1'b1; ig_size = 2'd3; dma_rdy = 1'b1;
    #2;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_vld0", 32'(dma_vld), 32'd1);
    chk("t1_rdy0", 32'(ig_rdy), 32'd1);
    step();
    #2 chk("t1_credit1", 32'(credit), 32'd252);
    step();
    #2 chk("t1_credit2", 32'(credit), 32'd248);
    step();
    #2;
    chk("t1_credit3", 32'(credit), 32'd244);
    chk("t1_vld_drain", 32'(dma_vld), 32'd0);
    chk("t1_busy_drain", 32'(busy), 32'd1);
    ig_vld = 1'b0;

    // eg_done arrives before the last four credits; layer_done waits for full credit.
    for (int i = 0; i < 8; i++) begin pop = 1'b1; step(); end
    pop = 1'b0; eg_done = 1'b1;
    #2 chk("t5_credit_eg", 32'(credit), 32'd252);
    step();
    eg_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      #2 chk("t5_no_done", 32'(layer_done), 32'd0);
      step();
    end
    pop = 1'b1;
    #2;
    chk("t5_credit_full", 32'(credit), 32'd256);
    chk("t5_done_early", 32'(layer_done), 32'd0);
    chk("t5_err_before", 32'(cerr), 32'd0);
    step();
    pop = 1'b0;
    #2;
    chk("t5_done", 32'(layer_done), 32'd1);
    chk("t5_credit_hold", 32'(credit), 32'd256);
    chk("t5_err", 32'(cerr), 32'd1);
    step();
    #2;
    chk("t5_done_pulse", 32'(layer_done), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    // Exhaust credits with size-3 requests, then return them one at a time.
    op_load = 1'b1; req_num = 22'd100;
    step();
    op_load = 1'b0; ig_vld = 1'b1; ig_size = 2'd3; dma_rdy = 1'b1;
    for (int i = 0; i < 64; i++) step();
    #2;
    chk("t2_credit0", 32'(credit), 32'd0);
    chk("t2_vld_stall", 32'(dma_vld), 32'd0);
    chk("t2_rdy_stall", 32'(ig_rdy), 32'd0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    #2;
    chk("t2_credit1", 32'(credit), 32'd1);
    chk("t2_still_stall", 32'(dma_vld), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin pop = 1'b1; step(); end
    pop = 1'b0; dma_rdy = 1'b0;
    #2;
    chk("t2_credit4", 32'(credit), 32'd4);
    chk("t2_vld_no_rdy", 32'(dma_vld), 32'd1);
    chk("t2_rdy_gated", 32'(ig_rdy), 32'd0);
    dma_rdy = 1'b1;
    #1 chk("t2_rdy", 32'(ig_rdy), 32'd1);
    step();
    ig_vld = 1'b0;
    #2;
    chk("t2_credit_after", 32'(credit), 32'd0);
`ifdef NVDLA_SDP_MRDMA_CREDIT_PERF_EN
    chk("t2_stall_num", stall_num, 32'd5);
`else
    chk("t2_stall_num", stall_num, 32'd0);
`endif

    // Accept and credit return in the same cycle: 5 - 2 + 1 = 4.
    for (int i = 0; i < 5; i++) begin pop = 1'b1; step(); end
    #2 chk("t3_credit5", 32'(credit), 32'd5);
    ig_vld = 1'b1; ig_size = 2'd1; pop = 1'b1;
    #1 chk("t3_rdy", 32'(ig_rdy), 32'd1);
    step();
    ig_vld = 1'b0; pop = 1'b0;
    #2 chk("t3_credit4", 32'(credit), 32'd4);

    // Bring credit to 100, try a stray op_load, then reset mid-RUN.
    for (int i = 0; i < 96; i++) begin pop = 1'b1; step(); end
    pop = 1'b0;
    #2 chk("t6_credit100", 32'(credit), 32'd100);
    op_load = 1'b1; req_num = 22'd0;
    step();
    op_load = 1'b0; ig_vld = 1'b1; ig_size = 2'd0;
    #2;
    chk("t6_opload_ignored", 32'(busy), 32'd1);
    chk("t6_vld_run", 32'(dma_vld), 32'd1);
`ifdef NVDLA_SDP_MRDMA_CREDIT_PERF_EN
    chk("t6_stall_kept", stall_num, 32'd5);
`endif
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_credit", 32'(credit), 32'd256);
    chk("t6_rst_vld", 32'(dma_vld), 32'd0);
    chk("t6_rst_rdy", 32'(ig_rdy), 32'd0);
    chk("t6_rst_err", 32'(cerr), 32'd0);
    ig_vld = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Empty layer: straight to DRAIN, eg_done two cycles later, single layer_done pulse.
    op_load = 1'b1; req_num = 22'd0; ig_vld = 1'b1;
    step();
    op_load = 1'b0;
    #2;
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_vld_drain", 32'(dma_vld), 32'd0);
    step();
    eg_done = 1'b1;
    #2 chk("t4_no_done0", 32'(layer_done), 32'd0);
    step();
    eg_done = 1'b0; ig_vld = 1'b0;
    #2 chk("t4_no_done1", 32'(layer_done), 32'd0);
    step();
    #2 chk("t4_done", 32'(layer_done), 32'd1);
    step();
    #2;
    chk("t4_done_pulse", 32'(layer_done), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_credit", 32'(credit), 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
